// File: rtl/counter_pkg.sv
// rtl/counter_pkg.sv - shared constants and control word for the counter processor
package counter_pkg;

    localparam int DEF_WIDTH = 8;
    localparam int DEF_LIMIT = 10;

    // Control word issued by the counter controller every cycle
    typedef struct packed {
        logic asrcSel;
        logic aLoad;
        logic outBufSel;
    } ctrl_word_t;

endpackage

// File: rtl/counter_datapath_if.sv
// rtl/counter_datapath_if.sv - controller/datapath bundle: control word in, status and display path out
interface counter_datapath_if #(
    parameter int WIDTH = counter_pkg::DEF_WIDTH
);

    logic             iAsrcSel;
    logic             iALoad;
    logic             iOutBufSel;
    logic             oAlt10;
    logic [WIDTH-1:0] oOutBuf;
    logic             oOutValid;
    logic             oDone;
    logic [WIDTH-1:0] oBufCount;

    modport master (
        output iAsrcSel, iALoad, iOutBufSel,
        input  oAlt10, oOutBuf, oOutValid, oDone, oBufCount
    );

    modport slave (
        input  iAsrcSel, iALoad, iOutBufSel,
        output oAlt10, oOutBuf, oOutValid, oDone, oBufCount
    );

endinterface

// File: rtl/counter_load_reg.sv
// rtl/counter_load_reg.sv - WIDTH-bit register with load enable and asynchronous reset
module counter_load_reg #(
    parameter int WIDTH = 8
) (
    input  logic             iClk,
    input  logic             iRst,
    input  logic             iLoad,
    input  logic [WIDTH-1:0] iD,
    output logic [WIDTH-1:0] oQ
);

    always_ff @(posedge iClk or posedge iRst) begin
        if (iRst) begin
            oQ <= '0;
        end else if (iLoad) begin
            oQ <= iD;
        end
    end

endmodule

// File: rtl/counter_datapath.sv
// rtl/counter_datapath.sv - A register, zero/increment mux, A<LIMIT comparator and display buffer
module counter_datapath
    import counter_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int LIMIT = DEF_LIMIT
) (
    input  logic              iClk,
    input  logic              iRst,
    counter_datapath_if.slave bus
);

    localparam logic [WIDTH-1:0] LIMIT_W = WIDTH'(LIMIT);

    ctrl_word_t       ctrl;
    logic [WIDTH-1:0] aQ;
    logic [WIDTH-1:0] aInc;
    logic [WIDTH-1:0] aNext;
    logic [WIDTH-1:0] outBufQ;
    logic             zeroLoad;
    logic             incLoad;
    logic             outValidQ;
    logic             doneQ;
    logic [WIDTH-1:0] bufCountQ;

    assign ctrl     = '{asrcSel: bus.iAsrcSel, aLoad: bus.iALoad, outBufSel: bus.iOutBufSel};
    assign aInc     = aQ + WIDTH'(1);
    assign aNext    = ctrl.asrcSel ? aInc : '0;
    assign zeroLoad = ctrl.aLoad & ~ctrl.asrcSel;
    assign incLoad  = ctrl.aLoad & ctrl.asrcSel;

    counter_load_reg #(.WIDTH(WIDTH)) uAReg (
        .iClk  (iClk),
        .iRst  (iRst),
        .iLoad (ctrl.aLoad),
        .iD    (aNext),
        .oQ    (aQ)
    );

    // Buffer samples the pre-update A, so a same-cycle increment is not seen
    counter_load_reg #(.WIDTH(WIDTH)) uOutBuf (
        .iClk  (iClk),
        .iRst  (iRst),
        .iLoad (ctrl.outBufSel),
        .iD    (aQ),
        .oQ    (outBufQ)
    );

    generate
        if (LIMIT == 0) begin : gNoCount
            assign bus.oAlt10 = 1'b0;
        end else begin : gCompare
            assign bus.oAlt10 = (aQ < LIMIT_W);
        end
    endgenerate

    always_ff @(posedge iClk or posedge iRst) begin
        if (iRst) begin
            outValidQ <= 1'b0;
            doneQ     <= 1'b0;
            bufCountQ <= '0;
        end else begin
            outValidQ <= ctrl.outBufSel;

            if (zeroLoad) begin
                doneQ <= (LIMIT == 0);
            end else if (incLoad && (aInc == LIMIT_W)) begin
                doneQ <= 1'b1;
            end

            // Clear takes priority, then the same-cycle capture is counted
            if (zeroLoad) begin
                bufCountQ <= WIDTH'(ctrl.outBufSel);
            end else if (ctrl.outBufSel && (bufCountQ != '1)) begin
                bufCountQ <= bufCountQ + WIDTH'(1);
            end
        end
    end

    assign bus.oOutBuf   = outBufQ;
    assign bus.oOutValid = outValidQ;
    assign bus.oDone     = doneQ;
    assign bus.oBufCount = bufCountQ;

endmodule

// File: tb/tb_counter_datapath.sv
// tb/tb_counter_datapath.sv - scoreboard bench for counter_datapath in three configurations
module tb_counter_datapath;

    logic iClk = 1'b0;
    logic iRst;
    always #5 iClk = ~iClk;

    counter_datapath_if #(.WIDTH(8)) bus0 ();
    counter_datapath_if #(.WIDTH(4)) bus1 ();
    counter_datapath_if #(.WIDTH(8)) bus2 ();

    counter_datapath #(.WIDTH(8), .LIMIT(10)) dut0 (.iClk(iClk), .iRst(iRst), .bus(bus0.slave));
    counter_datapath #(.WIDTH(4), .LIMIT(15)) dut1 (.iClk(iClk), .iRst(iRst), .bus(bus1.slave));
    counter_datapath #(.WIDTH(8), .LIMIT(0))  dut2 (.iClk(iClk), .iRst(iRst), .bus(bus2.slave));

    int passCnt  = 0;
    int totalCnt = 0;
    logic [7:0] expQ[$];
    int modelA = 0;

    task automatic step0(input logic asrc, input logic load, input logic cap);
        logic [7:0] want;
        if (cap) expQ.push_back(8'(modelA));
        if (load) modelA = asrc ? ((modelA + 1) % 256) : 0;
        bus0.iAsrcSel = asrc; bus0.iALoad = load; bus0.iOutBufSel = cap;
        @(posedge iClk); #1;
        bus0.iAsrcSel = 1'b0; bus0.iALoad = 1'b0; bus0.iOutBufSel = 1'b0;
        totalCnt++;
        if (bus0.oOutValid !== cap) $display("FAIL valid0: got %b want %b", bus0.oOutValid, cap);
        else passCnt++;
        if (bus0.oOutValid === 1'b1) begin
            totalCnt++;
            if (expQ.size() == 0) $display("FAIL sb_empty: got outBuf %0d want no publish", bus0.oOutBuf);
            else begin
                want = expQ.pop_front();
                if (bus0.oOutBuf !== want) $display("FAIL sb_outbuf: got %0d want %0d", bus0.oOutBuf, want);
                else passCnt++;
            end
        end
        totalCnt++;
        if (bus0.oAlt10 !== (modelA < 10)) $display("FAIL alt10_0: got %b want %b (A=%0d)", bus0.oAlt10, (modelA < 10), modelA);
        else passCnt++;
    endtask

    task automatic drive1(input logic asrc, input logic load, input logic cap);
        bus1.iAsrcSel = asrc; bus1.iALoad = load; bus1.iOutBufSel = cap;
        @(posedge iClk); #1;
        bus1.iAsrcSel = 1'b0; bus1.iALoad = 1'b0; bus1.iOutBufSel = 1'b0;
    endtask

    task automatic drive2(input logic asrc, input logic load, input logic cap);
        bus2.iAsrcSel = asrc; bus2.iALoad = load; bus2.iOutBufSel = cap;
        @(posedge iClk); #1;
        bus2.iAsrcSel = 1'b0; bus2.iALoad = 1'b0; bus2.iOutBufSel = 1'b0;
    endtask

    task automatic test_reset();
        iRst = 1'b1;
        repeat (2) @(posedge iClk);
        #1;
        totalCnt++; if (bus0.oAlt10 !== 1'b1) $display("FAIL rst_alt10: got %b want 1", bus0.oAlt10); else passCnt++;
        totalCnt++; if (bus0.oOutBuf !== 8'd0) $display("FAIL rst_outbuf: got %0d want 0", bus0.oOutBuf); else passCnt++;
        totalCnt++; if (bus0.oOutValid !== 1'b0) $display("FAIL rst_valid: got %b want 0", bus0.oOutValid); else passCnt++;
        totalCnt++; if (bus0.oDone !== 1'b0) $display("FAIL rst_done: got %b want 0", bus0.oDone); else passCnt++;
        totalCnt++; if (bus0.oBufCount !== 8'd0) $display("FAIL rst_count: got %0d want 0", bus0.oBufCount); else passCnt++;
        totalCnt++; if (bus2.oAlt10 !== 1'b0) $display("FAIL rst_alt10_lim0: got %b want 0", bus2.oAlt10); else passCnt++;
        iRst = 1'b0;
        step0(1'b0, 1'b1, 1'b0);
        repeat (5) step0(1'b1, 1'b1, 1'b0);
        step0(1'b1, 1'b0, 1'b1);
        step0(1'b0, 1'b0, 1'b0);
        totalCnt++; if (bus0.oOutBuf !== 8'd5) $display("FAIL pre_rst_outbuf: got %0d want 5", bus0.oOutBuf); else passCnt++;
        #2 iRst = 1'b1;
        #1;
        totalCnt++; if (bus0.oOutBuf !== 8'd0) $display("FAIL midrst_outbuf: got %0d want 0", bus0.oOutBuf); else passCnt++;
        totalCnt++; if (bus0.oBufCount !== 8'd0) $display("FAIL midrst_count: got %0d want 0", bus0.oBufCount); else passCnt++;
        totalCnt++; if (bus0.oDone !== 1'b0) $display("FAIL midrst_done: got %b want 0", bus0.oDone); else passCnt++;
        totalCnt++; if (bus0.oAlt10 !== 1'b1) $display("FAIL midrst_alt10: got %b want 1", bus0.oAlt10); else passCnt++;
        iRst = 1'b0;
        modelA = 0;
        expQ.delete();
        step0(1'b0, 1'b0, 1'b1);
    endtask

    task automatic test_full_sequence();
        step0(1'b0, 1'b1, 1'b0);
        totalCnt++; if (bus0.oBufCount !== 8'd0) $display("FAIL seq_count0: got %0d want 0", bus0.oBufCount); else passCnt++;
        for (int v = 0; v < 10; v++) begin
            step0(1'b0, 1'b0, 1'b1);
            step0(1'b1, 1'b1, 1'b0);
            totalCnt++;
            if (bus0.oDone !== (v == 9)) $display("FAIL seq_done: got %b want %b at v=%0d", bus0.oDone, (v == 9), v);
            else passCnt++;
            step0(1'b0, 1'b0, 1'b0);
        end
        totalCnt++; if (bus0.oBufCount !== 8'd10) $display("FAIL seq_count: got %0d want 10", bus0.oBufCount); else passCnt++;
        totalCnt++; if (bus0.oAlt10 !== 1'b0) $display("FAIL seq_alt10: got %b want 0", bus0.oAlt10); else passCnt++;
        totalCnt++; if (bus0.oOutBuf !== 8'd9) $display("FAIL seq_last: got %0d want 9", bus0.oOutBuf); else passCnt++;
    endtask

    task automatic test_same_cycle();
        step0(1'b0, 1'b1, 1'b0);
        repeat (3) step0(1'b1, 1'b1, 1'b0);
        step0(1'b1, 1'b1, 1'b1);
        totalCnt++; if (bus0.oOutBuf !== 8'd3) $display("FAIL same_outbuf: got %0d want 3", bus0.oOutBuf); else passCnt++;
        step0(1'b0, 1'b0, 1'b1);
        totalCnt++; if (bus0.oOutBuf !== 8'd4) $display("FAIL same_a: got %0d want 4", bus0.oOutBuf); else passCnt++;
    endtask

    task automatic test_hold();
        step0(1'b0, 1'b1, 1'b0);
        repeat (7) step0(1'b1, 1'b1, 1'b0);
        step0(1'b0, 1'b0, 1'b1);
        repeat (3) begin
            step0(1'b1, 1'b0, 1'b0);
            totalCnt++; if (bus0.oOutBuf !== 8'd7) $display("FAIL hold_outbuf: got %0d want 7", bus0.oOutBuf); else passCnt++;
            totalCnt++; if (bus0.oBufCount !== 8'd1) $display("FAIL hold_count: got %0d want 1", bus0.oBufCount); else passCnt++;
        end
        step0(1'b0, 1'b1, 1'b1);
        totalCnt++; if (bus0.oOutBuf !== 8'd7) $display("FAIL zcap_outbuf: got %0d want 7", bus0.oOutBuf); else passCnt++;
        totalCnt++; if (bus0.oBufCount !== 8'd1) $display("FAIL zcap_count: got %0d want 1", bus0.oBufCount); else passCnt++;
        totalCnt++; if (bus0.oDone !== 1'b0) $display("FAIL zcap_done: got %b want 0", bus0.oDone); else passCnt++;
        step0(1'b0, 1'b0, 1'b1);
        totalCnt++; if (bus0.oBufCount !== 8'd2) $display("FAIL zcap_count2: got %0d want 2", bus0.oBufCount); else passCnt++;
    endtask

    task automatic test_wrap();
        drive1(1'b0, 1'b1, 1'b0);
        repeat (14) drive1(1'b1, 1'b1, 1'b0);
        totalCnt++; if (bus1.oDone !== 1'b0) $display("FAIL wrap_done14: got %b want 0", bus1.oDone); else passCnt++;
        drive1(1'b1, 1'b1, 1'b0);
        totalCnt++; if (bus1.oDone !== 1'b1) $display("FAIL wrap_done15: got %b want 1", bus1.oDone); else passCnt++;
        totalCnt++; if (bus1.oAlt10 !== 1'b0) $display("FAIL wrap_alt10_15: got %b want 0", bus1.oAlt10); else passCnt++;
        drive1(1'b1, 1'b1, 1'b0);
        totalCnt++; if (bus1.oAlt10 !== 1'b1) $display("FAIL wrap_alt10_0: got %b want 1", bus1.oAlt10); else passCnt++;
        totalCnt++; if (bus1.oDone !== 1'b1) $display("FAIL wrap_done_kept: got %b want 1", bus1.oDone); else passCnt++;
        drive1(1'b0, 1'b0, 1'b1);
        totalCnt++; if (bus1.oOutBuf !== 4'd0) $display("FAIL wrap_a: got %0d want 0", bus1.oOutBuf); else passCnt++;
        repeat (19) drive1(1'b0, 1'b0, 1'b1);
        totalCnt++; if (bus1.oBufCount !== 4'd15) $display("FAIL wrap_sat: got %0d want 15", bus1.oBufCount); else passCnt++;
    endtask

    task automatic test_limit0();
        totalCnt++; if (bus2.oDone !== 1'b0) $display("FAIL lim0_done_pre: got %b want 0", bus2.oDone); else passCnt++;
        drive2(1'b0, 1'b1, 1'b0);
        totalCnt++; if (bus2.oDone !== 1'b1) $display("FAIL lim0_done: got %b want 1", bus2.oDone); else passCnt++;
        totalCnt++; if (bus2.oAlt10 !== 1'b0) $display("FAIL lim0_alt10: got %b want 0", bus2.oAlt10); else passCnt++;
        drive2(1'b1, 1'b1, 1'b0);
        totalCnt++; if (bus2.oAlt10 !== 1'b0) $display("FAIL lim0_alt10_a1: got %b want 0", bus2.oAlt10); else passCnt++;
    endtask

    initial begin
        iRst = 1'b1;
        bus0.iAsrcSel = 1'b0; bus0.iALoad = 1'b0; bus0.iOutBufSel = 1'b0;
        bus1.iAsrcSel = 1'b0; bus1.iALoad = 1'b0; bus1.iOutBufSel = 1'b0;
        bus2.iAsrcSel = 1'b0; bus2.iALoad = 1'b0; bus2.iOutBufSel = 1'b0;
        test_reset();
        test_full_sequence();
        test_same_cycle();
        test_hold();
        test_wrap();
        test_limit0();
        totalCnt++;
        if (expQ.size() != 0) $display("FAIL sb_leftover: got %0d pending want 0", expQ.size());
        else passCnt++;
        $display("%0d/%0d checks passed", passCnt, totalCnt);
        $finish;
    end

endmodule

// File: doc/counter_datapath.md
# counter_datapath

Datapath for the 0-to-LIMIT-1 counter dedicated processor. It executes the control word issued by the counter controller each cycle and returns the `A < LIMIT` status bit that drives the controller's branch. It holds the A register, its increment/zero source mux, the comparator and a registered output buffer. The buffer feeds the display path, with a valid strobe, a sticky done flag and a count of published values.

## Interface
Parameters:
- `WIDTH`, 8: width of the A register and the output buffer.
- `LIMIT`, 10: exclusive upper bound for the count; legal range 0 .. 2^WIDTH-1.

Ports:
- `iClk` in 1: single clock; all state updates on its rising edge.
- `iRst` in 1: reset, asynchronous and active-high.
- `iAsrcSel` in 1: A source select; 0 = constant zero, 1 = A+1.
- `iALoad` in 1: load enable for A.
- `iOutBufSel` in 1: capture A into the output buffer.
- `oAlt10` out 1: status, A < LIMIT (combinational from the A register).
- `oOutBuf` out WIDTH: last published count value.
- `oOutValid` out 1: one-cycle pulse; `oOutBuf` changed this cycle.
- `oDone` out 1: sticky; A has reached LIMIT since the last zero-load.
- `oBufCount` out WIDTH: number of buffer captures since the last zero-load. Saturates at 2^WIDTH-1.

## Operation
- **A register**
  - On `iALoad`=1, A <= (`iAsrcSel` ? A+1 : 0).
  - On `iALoad`=0, A holds and `iAsrcSel` is ignored.
  - A+1 is computed in WIDTH bits and wraps: 2^WIDTH-1 + 1 = 0.
- **Comparator:** `oAlt10` = (A < LIMIT), unsigned. With LIMIT=0, `oAlt10` is constantly 0.
- **Output buffer**
  - On `iOutBufSel`=1, `oOutBuf` <= A, and `oOutValid` is 1 in the following cycle.
  - Otherwise `oOutBuf` holds and `oOutValid` is 0.
- **Done flag**
  - Set on the edge where A is loaded with A+1 and A+1 == LIMIT.
  - Cleared by a zero-load (`iALoad`=1, `iAsrcSel`=0).
  - With LIMIT=0, set by any zero-load.
- **oBufCount**
  - Increments on each `iOutBufSel` capture.
  - Reset to 0 by a zero-load.
  - Holds at all-ones rather than wrapping.
- **Simultaneous events**
  - `iALoad` and `iOutBufSel` in the same cycle: the buffer captures the pre-update A.
  - Zero-load and `iOutBufSel` in the same cycle: `oBufCount` becomes 1 (clear first, then count the capture). `oDone` clears.
- **Reset values:** A=0, `oOutBuf`=0, `oOutValid`=0, `oDone`=0, `oBufCount`=0. Therefore `oAlt10`=1 for LIMIT>0.
- **Reset mid-operation:** all state returns to reset values immediately (asynchronous). No partial capture survives.

## Timing
- Zero latency from control inputs to register update: the update happens on the edge that samples them.
- `oAlt10` is valid in the cycle after the A update, with no extra register stage. This matches the controller evaluating the branch in the state following the increment.
- Buffer publish latency is 1 cycle from `iOutBufSel`; `oOutValid` is aligned with the new `oOutBuf`.
- `oDone` asserts in the same cycle `oAlt10` falls for the terminal value.
- Control sequence per counted value: capture cycle, increment cycle, compare cycle. That is 3 cycles per published value. LIMIT=10 gives 10 publishes (0..9).
- There is no handshake back-pressure: control inputs are obeyed unconditionally every cycle.

## Structure
- Shared package `counter_pkg`: default `WIDTH`/`LIMIT` constants and a packed control-word struct {asrc_sel, a_load, outbuf_sel}. The controller and the datapath share this struct.
- One natural sub-module, `counter_load_reg`: a WIDTH-bit register with load enable and async reset. It is instantiated for A and for the output buffer.
- Comparator, adder, mux, done flag and saturating counter stay in `counter_datapath`.

## Test plan
- **Reset:** assert `iRst` mid-run with A=5. Required: A=0, `oOutBuf`=0, `oBufCount`=0, `oDone`=0, `oAlt10`=1 immediately, without waiting for a clock edge.
- **Full controller sequence, LIMIT=10:** zero-load, then repeat {capture, increment, idle-compare}. Required: `oOutBuf` publishes 0..9, each with a single `oOutValid` pulse. `oAlt10` falls when A=10, `oDone` rises in the same cycle, and `oBufCount`=10.
- **Same-cycle increment and capture at A=3:** required `oOutBuf`=3, A=4.
- **Wrap-around, WIDTH=4, LIMIT=15:** increment from A=15. Required A=0, `oAlt10`=1, `oDone` stays 1 (set at 15, not cleared by the wrap).
- **`iAsrcSel`=1 with `iALoad`=0 at A=7:** required A stays 7 and no outputs change. Then zero-load with capture: `oOutBuf`=7, `oBufCount`=1, `oDone`=0.
- **LIMIT=0:** required `oAlt10`=0 from reset, and `oDone`=1 after the first zero-load.
